// File: rtl/arty_boot_seq.sv
// arty_boot_seq: holds the PULPino SoC in reset until MMCM lock is stable, then releases it and gates fetch enable.
module arty_boot_seq #(
  parameter int LOCK_WAIT_CYCLES = 1024,
  parameter int RST_HOLD_CYCLES  = 256,
  parameter int FETCH_DELAY      = 16,
  parameter int DEBOUNCE_CYCLES  = 500000,
  parameter bit AUTO_FETCH       = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked_i,
  input  logic       fetch_btn_i,
  output logic       soc_rst_n_o,
  output logic       fetch_enable_o,
  output logic [1:0] boot_state_o
);
  localparam int LW = $clog2(LOCK_WAIT_CYCLES + 1);
  localparam int HW = $clog2(RST_HOLD_CYCLES + 1);
  localparam int RW = $clog2(FETCH_DELAY + 1);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_WAIT_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD_CYCLES - 1);
  localparam logic [RW-1:0] RUN_MAX   = RW'(FETCH_DELAY);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {RESET, WAIT_LOCK, HOLD, RUN} state_t;

  state_t        state, state_nx;
  logic [1:0]    lock_sync, btn_sync;
  logic          lock, btn;
  logic [LW-1:0] lock_cnt;
  logic [HW-1:0] hold_cnt;
  logic [RW-1:0] run_cnt, run_nx;
  logic [DW-1:0] db_cnt;
  logic          btn_db, btn_db_q, fetch_req, fetch_req_nx;

  assign lock = lock_sync[1];
  assign btn = btn_sync[1];
  assign boot_state_o = state;

  always_comb begin
    state_nx = (state == RESET || !lock) ? WAIT_LOCK
             : state == WAIT_LOCK ? (lock_cnt == LOCK_LAST ? HOLD : WAIT_LOCK)
             : state == HOLD ? (hold_cnt == HOLD_LAST ? RUN : HOLD)
             : RUN;
    run_nx = (state == RUN && state_nx == RUN) ? (run_cnt == RUN_MAX ? run_cnt : run_cnt + 1'b1) : '0;
    // entering WAIT_LOCK beats a simultaneous debounced press
    fetch_req_nx = (state_nx == WAIT_LOCK && state != WAIT_LOCK) ? 1'b0 : fetch_req | (btn_db & ~btn_db_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_sync      <= '0;
      btn_sync       <= '0;
      state          <= RESET;
      lock_cnt       <= '0;
      hold_cnt       <= '0;
      run_cnt        <= '0;
      db_cnt         <= '0;
      btn_db         <= 1'b0;
      btn_db_q       <= 1'b0;
      fetch_req      <= 1'b0;
      soc_rst_n_o    <= 1'b0;
      fetch_enable_o <= 1'b0;
    end else begin
      lock_sync      <= {lock_sync[0], pll_locked_i};
      btn_sync       <= {btn_sync[0], fetch_btn_i};
      state          <= state_nx;
      lock_cnt       <= (state == WAIT_LOCK && state_nx == WAIT_LOCK && lock) ? lock_cnt + 1'b1 : '0;
      hold_cnt       <= (state == HOLD && state_nx == HOLD) ? hold_cnt + 1'b1 : '0;
      run_cnt        <= run_nx;
      db_cnt         <= (btn == btn_db || db_cnt == DB_LAST) ? '0 : db_cnt + 1'b1;
      btn_db         <= (btn != btn_db && db_cnt == DB_LAST) ? btn : btn_db;
      btn_db_q       <= btn_db;
      fetch_req      <= fetch_req_nx;
      soc_rst_n_o    <= state_nx == RUN;
      fetch_enable_o <= state_nx == RUN && (fetch_enable_o || (run_nx == RUN_MAX && (AUTO_FETCH || fetch_req_nx)));
    end
  end
endmodule
